// File: rtl/fix_ari_mul_if.sv
// Operand/result bundle for the pipelined fixed-point multiplier.
// The master drives the operands; the slave (multiplier) returns both products.
interface fix_ari_mul_if #(
    parameter int WIDTH = 16
);
    logic signed [WIDTH-1:0]   data_in1;
    logic signed [WIDTH-1:0]   data_in2;
    logic signed [2*WIDTH-2:0] data_out;
    logic signed [WIDTH-1:0]   data_out_round;

    modport master (
        output data_in1,
        output data_in2,
        input  data_out,
        input  data_out_round
    );

    modport slave (
        input  data_in1,
        input  data_in2,
        output data_out,
        output data_out_round
    );
endinterface

// File: rtl/fix_ari_mul.sv
// Three-stage signed fixed-point multiplier: full product plus a saturated product >>> FRAC.
// Define FIX_ARI_MUL_ROUND_NEAREST_EN for round-half-up on data_out_round instead of floor.
module fix_ari_mul #(
    parameter int WIDTH = 16,
    parameter int FRAC  = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    fix_ari_mul_if.slave bus
);
    localparam int PW = 2 * WIDTH;

    // Saturation limits expressed on the already-shifted value.
    localparam logic signed [PW-1:0] Q_MAX = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [PW-1:0] Q_MIN = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

`ifdef FIX_ARI_MUL_ROUND_NEAREST_EN
    localparam logic signed [PW-1:0] RND = {{(PW-1){1'b0}}, 1'b1} << (FRAC - 1);
`endif

    logic signed [WIDTH-1:0] a_reg, b_reg;
    logic signed [PW-1:0]    prod_reg;
    logic signed [PW-2:0]    data_out_reg;
    logic signed [WIDTH-1:0] round_reg;

    logic signed [PW-1:0]    a_ext, b_ext;
    logic signed [PW-1:0]    prod_next;
    logic signed [PW-1:0]    prod_adj;
    logic signed [PW-1:0]    q_shift;
    logic signed [WIDTH-1:0] round_next;

    // The full product of two WIDTH-bit operands always fits in 2*WIDTH bits.
    always_comb begin
        a_ext     = a_reg;
        b_ext     = b_reg;
        prod_next = a_ext * b_ext;
    end

    // Saturating against the shifted full product is equivalent to comparing P with MAX/MIN.
    always_comb begin
        prod_adj = prod_reg;
`ifdef FIX_ARI_MUL_ROUND_NEAREST_EN
        prod_adj = prod_reg + RND;
`endif
        q_shift    = prod_adj >>> FRAC;
        round_next = q_shift[WIDTH-1:0];
        if (q_shift > Q_MAX) begin
            round_next = Q_MAX[WIDTH-1:0];
        end else if (q_shift < Q_MIN) begin
            round_next = Q_MIN[WIDTH-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_reg        <= '0;
            b_reg        <= '0;
            prod_reg     <= '0;
            data_out_reg <= '0;
            round_reg    <= '0;
        end else begin
            a_reg        <= bus.data_in1;
            b_reg        <= bus.data_in2;
            prod_reg     <= prod_next;
            data_out_reg <= prod_reg[PW-2:0];
            round_reg    <= round_next;
        end
    end

    assign bus.data_out       = data_out_reg;
    assign bus.data_out_round = round_reg;
endmodule

// File: tb/tb_fix_ari_mul.sv
// Directed self-checking bench for fix_ari_mul (Q8.8 defaults).
module tb_fix_ari_mul;
    localparam int WIDTH = 16;
    localparam int FRAC  = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   errors = 0;
    int   checks = 0;

    fix_ari_mul_if #(.WIDTH(WIDTH)) bus ();

    fix_ari_mul #(.WIDTH(WIDTH), .FRAC(FRAC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected saturated result taken straight from the arithmetic definition.
    function automatic logic signed [15:0] ref_round(input longint p);
        longint q;
`ifdef FIX_ARI_MUL_ROUND_NEAREST_EN
        q = (p + 128) >>> 8;
`else
        q = p >>> 8;
`endif
        if (q > 32767) return 16'sd32767;
        if (q < -32768) return -16'sd32768;
        return 16'(q);
    endfunction

    task automatic test_reset();
        bus.data_in1 = -16'sd20000;
        bus.data_in2 = 16'sd500;
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if (bus.data_out !== 31'sd0 || bus.data_out_round !== 16'sd0) begin
            errors++;
            $display("FAIL reset_hold: data_out=%0d round=%0d required 0 0", bus.data_out, bus.data_out_round);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (bus.data_out !== 31'sd0 || bus.data_out_round !== 16'sd0) begin
                errors++;
                $display("FAIL reset_release_zero%0d: data_out=%0d round=%0d required 0 0",
                         k, bus.data_out, bus.data_out_round);
            end
        end
        step();
        checks++;
        if (bus.data_out !== -31'sd10000000 || bus.data_out_round !== -16'sd32768) begin
            errors++;
            $display("FAIL reset_first_product: data_out=%0d round=%0d required -10000000 -32768",
                     bus.data_out, bus.data_out_round);
        end
    endtask

    task automatic test_ramp();
        logic signed [15:0] in1_hist[100];
        logic signed [15:0] in2_hist[100];
        longint             p;
        logic signed [30:0] exp_out;
        logic signed [15:0] exp_rnd;
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        for (int k = 0; k < 102; k++) begin
            if (k < 100) begin
                in1_hist[k]  = 16'(-20000 + 400 * k);
                in2_hist[k]  = 16'(500 + 10 * k);
                bus.data_in1 = in1_hist[k];
                bus.data_in2 = in2_hist[k];
            end
            step();
            if (k >= 2) begin
                p       = longint'(in1_hist[k-2]) * longint'(in2_hist[k-2]);
                exp_out = p[30:0];
                exp_rnd = ref_round(p);
                checks++;
                if (bus.data_out !== exp_out || bus.data_out_round !== exp_rnd) begin
                    errors++;
                    $display("FAIL ramp[%0d] %0d*%0d: data_out=%0d round=%0d required %0d %0d",
                             k-2, in1_hist[k-2], in2_hist[k-2], bus.data_out, bus.data_out_round,
                             exp_out, exp_rnd);
                end
            end
        end
    endtask

    // Boundary and corner vectors issued on consecutive clocks.
    task automatic test_back_to_back();
        localparam int N = 9;
        logic signed [15:0] va[N];
        logic signed [15:0] vb[N];
        logic signed [30:0] vo[N];
        logic signed [15:0] vr[N];
        va[0] = 16'sd1024;   vb[0] = 16'sd8192;   vo[0] = 31'sd8388608;     vr[0] = 16'sd32767;
        va[1] = -16'sd1024;  vb[1] = 16'sd8192;   vo[1] = -31'sd8388608;    vr[1] = -16'sd32768;
        va[2] = 16'sd1023;   vb[2] = 16'sd8195;   vo[2] = 31'sd8383485;
`ifdef FIX_ARI_MUL_ROUND_NEAREST_EN
        vr[2] = 16'sd32748;
`else
        vr[2] = 16'sd32747;
`endif
        va[3] = -16'sd1023;  vb[3] = 16'sd8195;   vo[3] = -31'sd8383485;    vr[3] = -16'sd32748;
        va[4] = -16'sd32768; vb[4] = -16'sd32768; vo[4] = -31'sd1073741824; vr[4] = 16'sd32767;
        va[5] = 16'sd256;    vb[5] = 16'sd256;    vo[5] = 31'sd65536;       vr[5] = 16'sd256;
        va[6] = -16'sd3;     vb[6] = 16'sd1;      vo[6] = -31'sd3;
`ifdef FIX_ARI_MUL_ROUND_NEAREST_EN
        vr[6] = 16'sd0;
`else
        vr[6] = -16'sd1;
`endif
        va[7] = 16'sd32767;  vb[7] = -16'sd32768; vo[7] = -31'sd1073709056; vr[7] = -16'sd32768;
        va[8] = 16'sd100;    vb[8] = 16'sd200;    vo[8] = 31'sd20000;       vr[8] = 16'sd78;
        for (int k = 0; k < N + 2; k++) begin
            if (k < N) begin
                bus.data_in1 = va[k];
                bus.data_in2 = vb[k];
            end
            step();
            if (k >= 2) begin
                checks++;
                if (bus.data_out !== vo[k-2] || bus.data_out_round !== vr[k-2]) begin
                    errors++;
                    $display("FAIL vec%0d %0d*%0d: data_out=%0d round=%0d required %0d %0d",
                             k-2, va[k-2], vb[k-2], bus.data_out, bus.data_out_round,
                             vo[k-2], vr[k-2]);
                end
            end
        end
    endtask

    task automatic test_reset_midstream();
        bus.data_in1 = 16'sd1000;
        bus.data_in2 = 16'sd1000;
        step();
        step();
        rst_n = 1'b0;
        step();
        checks++;
        if (bus.data_out !== 31'sd0 || bus.data_out_round !== 16'sd0) begin
            errors++;
            $display("FAIL midstream_reset: data_out=%0d round=%0d required 0 0", bus.data_out, bus.data_out_round);
        end
        bus.data_in1 = 16'sd7;
        bus.data_in2 = 16'sd9;
        rst_n = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if (bus.data_out !== 31'sd0 || bus.data_out_round !== 16'sd0) begin
                errors++;
                $display("FAIL midstream_flush%0d: data_out=%0d round=%0d required 0 0",
                         k, bus.data_out, bus.data_out_round);
            end
        end
        step();
        checks++;
        if (bus.data_out !== 31'sd63 || bus.data_out_round !== 16'sd0) begin
            errors++;
            $display("FAIL midstream_resume: data_out=%0d round=%0d required 63 0", bus.data_out, bus.data_out_round);
        end
    endtask

    initial begin
        bus.data_in1 = '0;
        bus.data_in2 = '0;
        #2;
        test_reset();
        test_ramp();
        test_back_to_back();
        test_reset_midstream();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
